// File: rtl/i2s_tx_wb.sv
// Wishbone-controlled I2S master transmitter: TX FIFO, I2S/left-justified framing,
// mono replay, underrun/overflow flags and a level/underrun interrupt.
//   state   | meaning
//   ST_IDLE | EN low; SCK/WS/SD parked at 0, position counters cleared
//   ST_RUN  | SCK running, frame in progress
module i2s_tx_wb #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DATA_W     = 16,
    parameter int          SLOT_W     = 32,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        i2s_sck_o,
    output logic        i2s_ws_o,
    output logic        i2s_sd_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(SLOT_W);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              st_q, st_d;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic                en_q, mono_q, lj_q;
    logic [7:0]          div_q, thresh_q;
    logic [1:0]          irqen_q;
    logic                underrun_q, overflow_q, irq_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          tick_q, tick_d, div_a_q, div_a_d;
    logic                sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
    logic                mono_a_q, mono_a_d, lj_a_q, lj_a_d;
    logic [BW-1:0]       pos_q, pos_d;
    logic [DATA_W-1:0]   sh_q, sh_d, hold_q, hold_d;

    logic                req, wr, rd, push_req, push, pop, ovf_set, underrun_set;
    logic                fifo_full, fifo_empty, stat_w1c, irq_d;
    logic [1:0]          reg_sel;
    logic [31:0]         rdata;
    logic [8:0]          cnt9;
    logic [7:0]          level;
    logic                launch, reload, frame_start, slot_n;
    logic [BW-1:0]       pos_n, msb_pos;
    logic [7:0]          div_n;
    logic                mono_n, lj_n;
    logic [DATA_W-1:0]   word;
    logic                unused_ok;

    assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i};

    assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign wr       = req & wbs_we_i;
    assign rd       = req & ~wbs_we_i;
    assign reg_sel  = wbs_adr_i[3:2];
    assign push_req = wr & (reg_sel == 2'd2);
    assign stat_w1c = wr & (reg_sel == 2'd1) & wbs_sel_i[0];

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign cnt9       = 9'(cnt_q);
    assign level      = cnt9[8] ? 8'hFF : cnt9[7:0];

    // A push into a full FIFO is still accepted when the serial side pops that cycle.
    assign push    = push_req & (~fifo_full | pop);
    assign ovf_set = push_req & fifo_full & ~pop;
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

    assign irq_d = (irqen_q[0] & en_q & (cnt9 <= {1'b0, thresh_q})) | (irqen_q[1] & underrun_q);

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0:    rdata = {8'h00, thresh_q, div_q, 5'b0, lj_q, mono_q, en_q};
            2'd1:    rdata = {16'h0000, level, 4'b0, overflow_q, underrun_q, fifo_empty, fifo_full};
            2'd3:    rdata = {30'b0, irqen_q};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        st_d = st_q;  tick_d = tick_q;  sck_d = sck_q;  ws_d = ws_q;  sd_d = sd_q;
        pos_d = pos_q;  sh_d = sh_q;  hold_d = hold_q;
        div_a_d = div_a_q;  mono_a_d = mono_a_q;  lj_a_d = lj_a_q;
        launch = 1'b0;  reload = 1'b0;  frame_start = 1'b0;
        slot_n = ws_q;  pos_n = pos_q;
        pop = 1'b0;  underrun_set = 1'b0;  word = '0;

        if (!en_q) begin
            st_d = ST_IDLE;  tick_d = '0;  sck_d = 1'b0;  ws_d = 1'b0;  sd_d = 1'b0;
            pos_d = '0;  sh_d = '0;
        end else if (st_q == ST_IDLE) begin
            // Enabling acts as a virtual falling edge at the start of the left slot.
            st_d = ST_RUN;  sck_d = 1'b0;  launch = 1'b1;  reload = 1'b1;
            frame_start = 1'b1;  slot_n = 1'b0;  pos_n = '0;
        end else if (tick_q == 8'd0) begin
            sck_d  = ~sck_q;
            reload = 1'b1;
            if (sck_q) begin
                launch = 1'b1;
                if (pos_q == BW'(SLOT_W - 1)) begin
                    pos_n  = '0;
                    slot_n = ~ws_q;
                end else begin
                    pos_n = pos_q + BW'(1);
                end
                frame_start = ~slot_n & (pos_n == '0);
            end
        end else begin
            tick_d = tick_q - 8'd1;
        end

        // Configuration written while running is adopted only at a frame start.
        div_n   = frame_start ? div_q  : div_a_q;
        mono_n  = frame_start ? mono_q : mono_a_q;
        lj_n    = frame_start ? lj_q   : lj_a_q;
        msb_pos = lj_n ? '0 : BW'(1);

        if (reload)
            tick_d = div_n;

        if (launch) begin
            ws_d = slot_n;  pos_d = pos_n;
            div_a_d = div_n;  mono_a_d = mono_n;  lj_a_d = lj_n;
            if (pos_n == msb_pos) begin
                if (!mono_n || !slot_n) begin
                    word         = fifo_empty ? '0 : mem_q[rd_ptr_q];
                    pop          = ~fifo_empty;
                    underrun_set = fifo_empty;
                    hold_d       = word;
                end else begin
                    word = hold_q;
                end
                sd_d = word[DATA_W-1];
                sh_d = word << 1;
            end else begin
                sd_d = sh_q[DATA_W-1];
                sh_d = sh_q << 1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= wbs_dat_i[DATA_W-1:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            st_q <= ST_IDLE;  ack_q <= 1'b0;  dat_q <= '0;
            en_q <= 1'b0;  mono_q <= 1'b0;  lj_q <= 1'b0;
            div_q <= '0;  thresh_q <= '0;  irqen_q <= '0;
            underrun_q <= 1'b0;  overflow_q <= 1'b0;  irq_q <= 1'b0;
            wr_ptr_q <= '0;  rd_ptr_q <= '0;  cnt_q <= '0;
            tick_q <= '0;  sck_q <= 1'b0;  ws_q <= 1'b0;  sd_q <= 1'b0;
            pos_q <= '0;  sh_q <= '0;  hold_q <= '0;
            div_a_q <= '0;  mono_a_q <= 1'b0;  lj_a_q <= 1'b0;
        end else begin
            st_q <= st_d;
            ack_q <= req;
            dat_q <= rd ? rdata : '0;
            if (wr && reg_sel == 2'd0) begin
                if (wbs_sel_i[0]) begin
                    en_q   <= wbs_dat_i[0];
                    mono_q <= wbs_dat_i[1];
                    lj_q   <= wbs_dat_i[2];
                end
                if (wbs_sel_i[1]) div_q    <= wbs_dat_i[15:8];
                if (wbs_sel_i[2]) thresh_q <= wbs_dat_i[23:16];
            end
            if (wr && reg_sel == 2'd3 && wbs_sel_i[0])
                irqen_q <= wbs_dat_i[1:0];
            underrun_q <= underrun_set | (underrun_q & ~(stat_w1c & wbs_dat_i[2]));
            overflow_q <= ovf_set | (overflow_q & ~(stat_w1c & wbs_dat_i[3]));
            irq_q <= irq_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            tick_q <= tick_d;  sck_q <= sck_d;  ws_q <= ws_d;  sd_q <= sd_d;
            pos_q <= pos_d;  sh_q <= sh_d;  hold_q <= hold_d;
            div_a_q <= div_a_d;  mono_a_q <= mono_a_d;  lj_a_q <= lj_a_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign i2s_sck_o = sck_q;
    assign i2s_ws_o  = ws_q;
    assign i2s_sd_o  = sd_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_i2s_tx_wb.sv
// Directed bench for i2s_tx_wb: register table plus serial-frame sequences
// checked against a bench-side model of the I2S/LJ bit placement.
module tb_i2s_tx_wb;
    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_DATA = 32'h3000_0008;
    localparam logic [31:0] A_IRQ  = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, sck, ws, sd, irq;
    logic [31:0] rdat_o;

    i2s_tx_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
        .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cap_n = 0;
    logic cap_ws [4096];
    logic cap_sd [4096];
    time  cap_t  [4096];

    always @(posedge sck) begin
        if (cap_n < 4096) begin
            cap_ws[cap_n] = ws;
            cap_sd[cap_n] = sd;
            cap_t[cap_n]  = $time;
            cap_n++;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] r, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        lat = 0; r = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                r = rdat_o;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, a, 4'hF, d, r, lat);
        chk("wr_ack", 32'(lat), 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        int lat;
        wb_xfer(1'b0, a, 4'hF, 32'h0, r, lat);
        chk("rd_ack", 32'(lat), 32'd1);
    endtask

    task automatic wait_caps(input int n, input string nm);
        for (int i = 0; i < 20000 && cap_n < n; i++) @(posedge clk);
        if (cap_n < n) chk(nm, 32'(cap_n), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] get_word(input int start);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) w = {w[14:0], cap_sd[start + i]};
        return 32'(w);
    endfunction

    initial begin
        logic [31:0] r;
        logic [15:0] wd;
        int lat, base, base2, bad_ws, bad_sd, n0, p, e_sd, e_ws;

        vecs[0]  = '{we:1'b0, adr:A_STAT, sel:4'hF, dat:32'h0,         exp:32'h0000_0002, lat:1};
        vecs[1]  = '{we:1'b1, adr:A_CTRL, sel:4'hF, dat:32'h0004_0306, exp:32'h0,         lat:1};
        vecs[2]  = '{we:1'b0, adr:A_CTRL, sel:4'hF, dat:32'h0,         exp:32'h0004_0306, lat:1};
        vecs[3]  = '{we:1'b1, adr:A_CTRL, sel:4'h2, dat:32'hFFFF_FFFF, exp:32'h0,         lat:1};
        vecs[4]  = '{we:1'b0, adr:A_CTRL, sel:4'hF, dat:32'h0,         exp:32'h0004_FF06, lat:1};
        vecs[5]  = '{we:1'b1, adr:A_CTRL, sel:4'hF, dat:32'h0,         exp:32'h0,         lat:1};
        vecs[6]  = '{we:1'b0, adr:A_CTRL, sel:4'hF, dat:32'h0,         exp:32'h0,         lat:1};
        vecs[7]  = '{we:1'b1, adr:A_IRQ,  sel:4'h1, dat:32'hFFFF_FFFF, exp:32'h0,         lat:1};
        vecs[8]  = '{we:1'b0, adr:A_IRQ,  sel:4'hF, dat:32'h0,         exp:32'h0000_0003, lat:1};
        vecs[9]  = '{we:1'b1, adr:A_IRQ,  sel:4'hF, dat:32'h0,         exp:32'h0,         lat:1};
        vecs[10] = '{we:1'b0, adr:A_IRQ,  sel:4'hF, dat:32'h0,         exp:32'h0,         lat:1};
        vecs[11] = '{we:1'b0, adr:A_DATA, sel:4'hF, dat:32'h0,         exp:32'h0,         lat:1};
        vecs[12] = '{we:1'b1, adr:A_DATA, sel:4'hF, dat:32'h0000_1234, exp:32'h0,         lat:1};
        vecs[13] = '{we:1'b0, adr:A_STAT, sel:4'hF, dat:32'h0,         exp:32'h0000_0100, lat:1};
        vecs[14] = '{we:1'b1, adr:A_DATA, sel:4'h0, dat:32'h0000_ABCD, exp:32'h0,         lat:1};
        vecs[15] = '{we:1'b0, adr:A_STAT, sel:4'hF, dat:32'h0,         exp:32'h0000_0200, lat:1};
        vecs[16] = '{we:1'b0, adr:32'h3000_0010, sel:4'hF, dat:32'h0,  exp:32'h0,         lat:0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {27'b0, sck, ws, sd, irq, ack}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, r, lat);
            chk($sformatf("vec%0d_ack", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].we && vecs[i].lat != 0)
                chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
        end
        rd(A_CTRL, r);
        @(posedge clk); #1;
        chk("dat_idle_zero", rdat_o, 32'h0);

        // Stereo I2S, DIV=1
        do_reset();
        wr(A_CTRL, 32'h0000_0100);
        wr(A_DATA, 32'h0000_A5A5);
        wr(A_DATA, 32'h0000_5A5A);
        base = cap_n;
        wr(A_CTRL, 32'h0000_0101);
        wait_caps(base + 66, "s2_timeout");
        bad_ws = 0; bad_sd = 0;
        for (int k = 0; k <= 64; k++) begin
            p = k % 32;
            wd = (k < 32) ? 16'hA5A5 : (k < 64) ? 16'h5A5A : 16'h0000;
            e_sd = (p >= 1 && p <= 16) ? int'(wd[16 - p]) : 0;
            e_ws = (k >= 32 && k < 64) ? 1 : 0;
            if (int'(cap_sd[base + k]) != e_sd) bad_sd++;
            if (int'(cap_ws[base + k]) != e_ws) bad_ws++;
        end
        chk("s2_ws_pattern", 32'(bad_ws), 32'd0);
        chk("s2_sd_pattern", 32'(bad_sd), 32'd0);
        chk("s2_left_word", get_word(base + 1), 32'h0000_A5A5);
        chk("s2_right_word", get_word(base + 33), 32'h0000_5A5A);
        chk("s2_sck_period", 32'(cap_t[base + 1] - cap_t[base]), 32'd40);
        rd(A_STAT, r);
        chk("s2_status_underrun", r, 32'h0000_0006);

        // Left-justified mono, DIV=0
        do_reset();
        wr(A_CTRL, 32'h0000_0006);
        wr(A_DATA, 32'h0000_8001);
        wr(A_DATA, 32'h0000_C003);
        base = cap_n;
        wr(A_CTRL, 32'h0000_0007);
        wait_caps(base + 10, "s3_timeout_a");
        rd(A_STAT, r);
        chk("s3_level_frame1", r, 32'h0000_0100);
        wait_caps(base + 74, "s3_timeout_b");
        rd(A_STAT, r);
        chk("s3_level_frame2", r, 32'h0000_0002);
        wait_caps(base + 128, "s3_timeout_c");
        bad_ws = 0; bad_sd = 0;
        for (int k = 0; k < 128; k++) begin
            p = k % 32;
            wd = (k < 64) ? 16'h8001 : 16'hC003;
            e_sd = (p < 16) ? int'(wd[15 - p]) : 0;
            e_ws = ((k % 64) >= 32) ? 1 : 0;
            if (int'(cap_sd[base + k]) != e_sd) bad_sd++;
            if (int'(cap_ws[base + k]) != e_ws) bad_ws++;
        end
        chk("s3_ws_pattern", 32'(bad_ws), 32'd0);
        chk("s3_sd_pattern", 32'(bad_sd), 32'd0);

        // Underrun interrupt and W1C
        do_reset();
        wr(A_IRQ, 32'h0000_0002);
        base = cap_n;
        wr(A_CTRL, 32'h0000_0001);
        wait_caps(base + 40, "s4_timeout");
        bad_sd = 0;
        for (int k = 0; k < 40; k++) if (cap_sd[base + k] !== 1'b0) bad_sd++;
        chk("s4_sd_zero", 32'(bad_sd), 32'd0);
        rd(A_STAT, r);
        chk("s4_status", r, 32'h0000_0006);
        chk("s4_irq_set", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h0000_0000);
        wr(A_STAT, 32'h0000_0004);
        chk("s4_irq_registered", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("s4_irq_cleared", 32'(irq), 32'd0);
        rd(A_STAT, r);
        chk("s4_status_cleared", r, 32'h0000_0002);

        // Overflow and level threshold
        do_reset();
        for (int k = 1; k <= 9; k++) wr(A_DATA, 32'(k));
        rd(A_STAT, r);
        chk("s5_full_overflow", r, 32'h0000_0809);
        wr(A_IRQ, 32'h0000_0001);
        wr(A_CTRL, 32'h0004_0000);
        chk("s5_irq_idle", 32'(irq), 32'd0);
        base = cap_n;
        wr(A_CTRL, 32'h0004_0001);
        for (int i = 0; i < 3000 && !irq; i++) begin
            @(posedge clk); #1;
        end
        chk("s5_irq_rise", 32'(irq), 32'd1);
        n0 = cap_n - base;
        chk("s5_irq_timing", 32'(n0 >= 96 && n0 <= 99), 32'd1);
        rd(A_STAT, r);
        chk("s5_level4", r, 32'h0000_0408);
        chk("s5_first_word", get_word(base + 1), 32'h0000_0001);
        chk("s5_second_word", get_word(base + 33), 32'h0000_0002);
        wr(A_STAT, 32'h0000_0008);
        rd(A_STAT, r);
        chk("s5_ovf_w1c", r, 32'h0000_0400);

        // Mid-frame disable and re-enable
        do_reset();
        wr(A_DATA, 32'h0000_1111);
        wr(A_DATA, 32'h0000_2222);
        wr(A_DATA, 32'h0000_3333);
        base = cap_n;
        wr(A_CTRL, 32'h0000_0101);
        wait_caps(base + 43, "s6_timeout_a");
        chk("s6_in_right_slot", 32'(ws), 32'd1);
        wr(A_CTRL, 32'h0000_0100);
        @(posedge clk); #1;
        chk("s6_outputs_off", {29'b0, sck, ws, sd}, 32'h0);
        n0 = cap_n;
        repeat (30) @(posedge clk);
        chk("s6_sck_quiet", 32'(cap_n - n0), 32'd0);
        rd(A_STAT, r);
        chk("s6_fifo_kept", r, 32'h0000_0100);
        base2 = cap_n;
        wr(A_CTRL, 32'h0000_0101);
        wait_caps(base2 + 34, "s6_timeout_b");
        chk("s6_restart_ws_left", 32'(cap_ws[base2]), 32'd0);
        chk("s6_restart_word", get_word(base2 + 1), 32'h0000_3333);
        chk("s6_restart_ws_right", 32'(cap_ws[base2 + 32]), 32'd1);

        // Asynchronous reset mid-frame
        do_reset();
        wr(A_IRQ, 32'h0000_0001);
        wr(A_CTRL, 32'h0008_0000);
        for (int k = 0; k < 3; k++) wr(A_DATA, 32'h0000_FFFF);
        base = cap_n;
        wr(A_CTRL, 32'h0008_0001);
        wait_caps(base + 38, "s1_timeout");
        #2;
        chk("s1_pre_reset", {29'b0, ws, sd, irq}, 32'h7);
        rst = 1'b1;
        #1;
        chk("s1_reset_outputs", {27'b0, sck, ws, sd, irq, ack}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(A_STAT, r);
        chk("s1_status_after_reset", r, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
